// File: rtl/rsc_dec_pkg.sv
// rtl/rsc_dec_pkg.sv - shared decoder types, widths and helpers
package rsc_dec_pkg;

  localparam int OBUF_N_W   = 13;
  localparam int OBUF_TAG_W = 8;
  localparam int OBUF_ERR_W = 16;

  typedef struct packed {
    logic [OBUF_N_W-1:0]   N;
    logic [OBUF_TAG_W-1:0] tag;
    logic [OBUF_ERR_W-1:0] err;
  } obuf_meta_t;

  function automatic int clogb2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r = r + 1;
    return r;
  endfunction

endpackage

// File: rtl/rsc_dec_obuf_meta.sv
// rtl/rsc_dec_obuf_meta.sv - per-bank frame metadata register file
// One write port, one asynchronous read port with same-cycle write bypass.
module rsc_dec_obuf_meta
  import rsc_dec_pkg::*;
#(
  parameter int pDATA_W  = OBUF_N_W + OBUF_TAG_W + OBUF_ERR_W,
  parameter int pBNUM    = 2,
  parameter int pBADDR_W = 1
) (
  input  logic                i_clk,
  input  logic                i_clkena,
  input  logic                i_we,
  input  logic [pBADDR_W-1:0] i_waddr,
  input  logic [pDATA_W-1:0]  i_wdata,
  input  logic [pBADDR_W-1:0] i_raddr,
  output logic [pDATA_W-1:0]  o_rdata
);

  logic [pDATA_W-1:0] r_mem [pBNUM];

  always_ff @(posedge i_clk) begin
    if (i_clkena && i_we) r_mem[i_waddr] <= i_wdata;
  end

  // A frame landing in the bank about to be presented must be seen this cycle.
  assign o_rdata = (i_we && (i_raddr == i_waddr)) ? i_wdata : r_mem[i_raddr];

endmodule

// File: rtl/rsc_dec_obuf_ctrl.sv
// rtl/rsc_dec_obuf_ctrl.sv - decoder output RAM bank ring controller
// Hands banks to the decoder engine and presents finished frames to the output sink.
module rsc_dec_obuf_ctrl
  import rsc_dec_pkg::*;
#(
  parameter int pW       = 13,
  parameter int pTAG_W   = 8,
  parameter int pBNUM    = 2,
  parameter int pBADDR_W = 1
) (
  input  logic                  iclk,
  input  logic                  ireset,
  input  logic                  iclkena,
  input  logic                  iwdone,
  input  logic [pW-1:0]         iwN,
  input  logic [pTAG_W-1:0]     iwtag,
  input  logic [15:0]           iwerr,
  output logic [pBADDR_W-1:0]   owbank,
  output logic                  owfull,
  input  logic                  irempty,
  output logic [pBADDR_W-1:0]   orbank,
  output logic                  ofull,
  output logic [pW-1:0]         oN,
  output logic [pTAG_W-1:0]     otag,
  output logic [15:0]           oerr,
  output logic                  oovf,
  output logic                  ounf
);

  localparam int lp_CNT_W  = clogb2(pBNUM) + 1;
  localparam int lp_META_W = pW + pTAG_W + OBUF_ERR_W;

  logic [pBADDR_W-1:0]  r_wptr, r_rptr;
  logic [lp_CNT_W-1:0]  r_used;
  logic [lp_META_W-1:0] r_meta;

  logic                 w_wr, w_rd;
  logic [pBADDR_W-1:0]  w_wptr_next, w_rptr_next;
  logic [lp_CNT_W-1:0]  w_used_next;
  logic [lp_META_W-1:0] w_rdata;

  assign w_wr = iwdone & ~owfull;
  assign w_rd = irempty & ofull;

  // Power-of-two ring: pointers wrap naturally at pBNUM.
  assign w_wptr_next = r_wptr + pBADDR_W'(w_wr);
  assign w_rptr_next = r_rptr + pBADDR_W'(w_rd);
  assign w_used_next = r_used + lp_CNT_W'(w_wr) - lp_CNT_W'(w_rd);

  rsc_dec_obuf_meta #(
    .pDATA_W  (lp_META_W),
    .pBNUM    (pBNUM),
    .pBADDR_W (pBADDR_W)
  ) u_meta (
    .i_clk    (iclk),
    .i_clkena (iclkena),
    .i_we     (w_wr),
    .i_waddr  (r_wptr),
    .i_wdata  ({iwN, iwtag, iwerr}),
    .i_raddr  (w_rptr_next),
    .o_rdata  (w_rdata)
  );

  always_ff @(posedge iclk or posedge ireset) begin
    if (ireset) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_used <= '0;
      r_meta <= '0;
      ofull  <= 1'b0;
      owfull <= 1'b0;
      oovf   <= 1'b0;
      ounf   <= 1'b0;
    end else if (iclkena) begin
      r_wptr <= w_wptr_next;
      r_rptr <= w_rptr_next;
      r_used <= w_used_next;
      r_meta <= w_rdata;
      ofull  <= (w_used_next != '0);
      owfull <= (w_used_next == lp_CNT_W'(pBNUM));
      if (iwdone && owfull) oovf <= 1'b1;
      if (irempty && !ofull) ounf <= 1'b1;
    end
  end

  assign owbank = r_wptr;
  assign orbank = r_rptr;
  assign {oN, otag, oerr} = r_meta;

endmodule

// File: tb/tb_rsc_dec_obuf_ctrl.sv
// tb/tb_rsc_dec_obuf_ctrl.sv - self-checking bench for rsc_dec_obuf_ctrl
module tb_rsc_dec_obuf_ctrl;

  localparam int NB = 2;

  logic        iclk, ireset, iclkena, iwdone, irempty;
  logic [12:0] iwN;
  logic [7:0]  iwtag;
  logic [15:0] iwerr;
  logic [0:0]  owbank, orbank;
  logic        owfull, ofull, oovf, ounf;
  logic [12:0] oN;
  logic [7:0]  otag;
  logic [15:0] oerr;

  rsc_dec_obuf_ctrl #(.pW(13), .pTAG_W(8), .pBNUM(NB), .pBADDR_W(1)) dut (
    .iclk(iclk), .ireset(ireset), .iclkena(iclkena),
    .iwdone(iwdone), .iwN(iwN), .iwtag(iwtag), .iwerr(iwerr),
    .owbank(owbank), .owfull(owfull),
    .irempty(irempty), .orbank(orbank), .ofull(ofull),
    .oN(oN), .otag(otag), .oerr(oerr), .oovf(oovf), .ounf(ounf)
  );

  initial iclk = 1'b0;
  always #5 iclk = ~iclk;

  typedef struct {
    logic [12:0] n;
    logic [7:0]  tag;
    logic [15:0] err;
  } frame_t;

  frame_t q[$];
  int     m_wp, m_rp;
  bit     m_ovf, m_unf;
  int     n_checks = 0;
  int     n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_wp = 0; m_rp = 0; m_ovf = 0; m_unf = 0;
  endtask

  // Ring as a FIFO of frames: admission decided on pre-edge occupancy.
  task automatic model_step();
    bit wr, rd;
    frame_t f;
    if (!iclkena) return;
    wr = iwdone && (q.size() < NB);
    rd = irempty && (q.size() > 0);
    if (iwdone && !wr) m_ovf = 1;
    if (irempty && !rd) m_unf = 1;
    if (rd) begin void'(q.pop_front()); m_rp = (m_rp + 1) % NB; end
    if (wr) begin
      f.n = iwN; f.tag = iwtag; f.err = iwerr;
      q.push_back(f);
      m_wp = (m_wp + 1) % NB;
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".ofull"},  ofull,  q.size() != 0);
    chk({tag, ".owfull"}, owfull, q.size() == NB);
    chk({tag, ".orbank"}, orbank, m_rp);
    chk({tag, ".owbank"}, owbank, m_wp);
    chk({tag, ".oovf"},   oovf,   m_ovf);
    chk({tag, ".ounf"},   ounf,   m_unf);
    if (q.size() != 0) begin
      chk({tag, ".oN"},   oN,   q[0].n);
      chk({tag, ".otag"}, otag, q[0].tag);
      chk({tag, ".oerr"}, oerr, q[0].err);
    end
  endtask

  task automatic tick();
    @(posedge iclk);
    model_step();
    #1;
    iwdone = 0;
    irempty = 0;
  endtask

  task automatic put(input logic [12:0] n, input logic [7:0] t, input logic [15:0] e);
    iwdone = 1; iwN = n; iwtag = t; iwerr = e;
  endtask

  task automatic do_reset();
    ireset = 1;
    #3;
    model_reset();
    @(negedge iclk);
    ireset = 0;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".ofull"}, ofull, 0);  chk({tag, ".owfull"}, owfull, 0);
    chk({tag, ".orbank"}, orbank, 0); chk({tag, ".owbank"}, owbank, 0);
    chk({tag, ".oN"}, oN, 0);        chk({tag, ".otag"}, otag, 0);
    chk({tag, ".oerr"}, oerr, 0);    chk({tag, ".oovf"}, oovf, 0);
    chk({tag, ".ounf"}, ounf, 0);
  endtask

  initial begin
    int sent, recv;
    ireset = 1; iclkena = 1; iwdone = 0; irempty = 0;
    iwN = '0; iwtag = '0; iwerr = '0;
    model_reset();
    #12;
    chk_zero("reset");
    ireset = 0;

    put(13'd2048, 8'h5A, 16'd17); tick(); check_all("t1");
    chk("t1.oN_abs", oN, 2048); chk("t1.otag_abs", otag, 8'h5A); chk("t1.owbank_abs", owbank, 1);

    put(13'd100, 8'h11, 16'd3); tick(); check_all("t2a");
    chk("t2.owfull_abs", owfull, 1);
    put(13'd7, 8'hEE, 16'd9); tick(); check_all("t2b");
    chk("t2.oovf_abs", oovf, 1); chk("t2.otag_keep", otag, 8'h5A);

    put(13'd55, 8'h22, 16'd1); irempty = 1; tick(); check_all("t3");
    chk("t3.orbank_abs", orbank, 1); chk("t3.otag_abs", otag, 8'h11); chk("t3.owfull_abs", owfull, 0);

    put(13'd77, 8'h33, 16'd2); irempty = 1; tick(); check_all("t4");
    chk("t4.otag_bypass", otag, 8'h33); chk("t4.ofull_abs", ofull, 1);

    do_reset();
    check_all("t5.reset");
    sent = 0; recv = 0;
    for (int cyc = 0; cyc < 2000 && recv < 10; cyc++) begin
      if (sent < 10 && q.size() < NB && $urandom_range(0, 1) == 1) begin
        put(13'($urandom), 8'(sent), 16'($urandom));
        sent++;
      end
      if (q.size() > 0 && $urandom_range(0, 2) == 0) begin
        irempty = 1;
        chk("t5.order", otag, recv);
        recv++;
      end
      tick();
      check_all("t5");
    end
    chk("t5.done", recv, 10);
    chk("t5.oovf_abs", oovf, 0); chk("t5.ounf_abs", ounf, 0);

    iclkena = 0; put(13'd9, 8'h99, 16'd9); tick(); check_all("t6.clkena");
    chk("t6.ofull_hold", ofull, 0);
    iclkena = 1;
    irempty = 1; tick(); check_all("t6.unf");
    chk("t6.ounf_abs", ounf, 1);

    put(13'd5, 8'h44, 16'd4); tick(); check_all("t6.pre");
    #2 ireset = 1;
    #1 chk_zero("t6.async");
    model_reset();
    @(negedge iclk); ireset = 0;
    tick(); check_all("t6.post");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
